// File: rtl/inst_fetch.sv
// inst_fetch: ARK fetch unit - PC drives InstAddress, one-entry Inst/InstPC/InstValid stage to decode, branch redirect, halt drain with Halted
module inst_fetch #(
  parameter int ADDR_W   = 8,
  parameter int INST_W   = 10,
  parameter int RESET_PC = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  output logic [ADDR_W-1:0] InstAddress,
  input  logic [INST_W-1:0] InstIn,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  output logic [INST_W-1:0] Inst,
  output logic [ADDR_W-1:0] InstPC,
  output logic              InstValid,
  input  logic              InstReady,
  output logic              Halted
);
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, ipc_q, ipc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                valid_q, valid_d;
  logic                free, halt_op;
  assign free    = !valid_q || InstReady;
  assign halt_op = &InstIn[INST_W-1:INST_W-4];
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (state_q == IDLE) begin
      state_d = Start ? FETCH : IDLE;
      pc_d    = Start ? RST_PC : pc_q;
    end else if (BranchTaken) begin
      state_d = FETCH;
      pc_d    = BranchTarget;
      valid_d = 1'b0;
    end else if (state_q == FETCH) begin
      if (free) begin
        inst_d  = InstIn;
        ipc_d   = pc_q;
        valid_d = 1'b1;
        state_d = halt_op ? HALT : FETCH;
        pc_d    = halt_op ? pc_q : pc_q + 1'b1;
      end
    end else begin
      valid_d = valid_q && !InstReady;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= RST_PC;
      ipc_q   <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end
  assign InstAddress = pc_q;
  assign Inst        = inst_q;
  assign InstPC      = ipc_q;
  assign InstValid   = valid_q;
  assign Halted      = (state_q == HALT) && !valid_q;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed plan plus randomized run of inst_fetch against a transaction-level fetch model
module tb_inst_fetch;
  logic       Clk = 1'b0, Reset_n = 1'b0;
  logic       start, br, ready;
  logic [7:0] tgt, addr, ipc;
  logic [9:0] inst_in, inst;
  logic       valid, halted;
  logic [9:0] rom [256];
  logic       start_w, ready_w, br_w;
  logic [7:0] tgt_w, addr_w, ipc_w;
  logic [9:0] inst_w;
  logic       valid_w, halted_w;
  int checks = 0, failures = 0;
  always #5 Clk = ~Clk;
  assign inst_in = rom[addr];
  inst_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(start), .InstAddress(addr), .InstIn(inst_in),
    .BranchTaken(br), .BranchTarget(tgt), .Inst(inst), .InstPC(ipc), .InstValid(valid),
    .InstReady(ready), .Halted(halted)
  );
  inst_fetch #(.RESET_PC(254)) dut_w (
    .Clk(Clk), .Reset_n(Reset_n), .Start(start_w), .InstAddress(addr_w), .InstIn(10'd0),
    .BranchTaken(br_w), .BranchTarget(tgt_w), .Inst(inst_w), .InstPC(ipc_w), .InstValid(valid_w),
    .InstReady(ready_w), .Halted(halted_w)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_inst"}, inst, 0);
    check({tag, "_ipc"}, ipc, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_halted"}, halted, 0);
  endtask
  task automatic random_run(input int cycles);
    bit         started, halt_cap, halt_done, p_start, p_br, p_ready, prev_valid;
    logic [7:0] exp_addr, p_tgt, prev_ipc;
    logic [9:0] prev_inst;
    for (int i = 0; i < 256; i++) rom[i] = 10'($urandom);
    @(negedge Clk);
    Reset_n = 1'b0;
    #2 Reset_n = 1'b1;
    started = 0; halt_cap = 0; halt_done = 0; prev_valid = 0; exp_addr = 0;
    prev_ipc = 0; prev_inst = 0;
    @(negedge Clk);
    p_start = 1; p_br = 0; p_ready = 1; p_tgt = 0;
    start = p_start; br = p_br; ready = p_ready; tgt = p_tgt;
    for (int c = 0; c < cycles; c++) begin
      @(negedge Clk);
      if (!started) begin
        check("rnd_idle_valid", valid, 0);
        if (p_start) begin
          started = 1;
          exp_addr = 0;
          check("rnd_start_addr", addr, 0);
        end
      end else if (p_br) begin
        check("rnd_br_valid", valid, 0);
        check("rnd_br_addr", addr, p_tgt);
        exp_addr = p_tgt; halt_cap = 0; halt_done = 0;
      end else if (prev_valid && !p_ready) begin
        check("rnd_stall_valid", valid, 1);
        check("rnd_stall_inst", inst, prev_inst);
        check("rnd_stall_ipc", ipc, prev_ipc);
        if (!halt_cap) check("rnd_stall_addr", addr, exp_addr);
      end else if (!halt_cap) begin
        check("rnd_cap_valid", valid, 1);
        check("rnd_cap_ipc", ipc, exp_addr);
        check("rnd_cap_inst", inst, rom[exp_addr]);
        if (rom[exp_addr][9:6] == 4'hF) halt_cap = 1;
        else begin
          exp_addr = exp_addr + 8'd1;
          check("rnd_cap_addr", addr, exp_addr);
        end
      end else begin
        check("rnd_halt_valid", valid, 0);
        halt_done = 1;
      end
      check("rnd_halted", halted, halt_done);
      prev_valid = valid; prev_inst = inst; prev_ipc = ipc;
      p_ready = $urandom_range(0, 9) < 7;
      p_br    = $urandom_range(0, 7) == 0;
      p_tgt   = 8'($urandom);
      p_start = $urandom_range(0, 15) == 0;
      start = p_start; br = p_br; ready = p_ready; tgt = p_tgt;
    end
    start = 0; br = 0;
  endtask
  initial begin
    start = 0; br = 0; ready = 0; tgt = 0;
    start_w = 0; ready_w = 0; br_w = 0; tgt_w = 0;
    for (int i = 0; i < 256; i++) rom[i] = 10'd0;
    rom[0] = 10'b0000000001; rom[1] = 10'b0001001001; rom[2] = 10'b0010000001;
    rom[3] = 10'b0011001001; rom[4] = 10'b1111111111;
    #12;
    check_reset("por");
    Reset_n = 1'b1;
    @(negedge Clk);
    start = 1; ready = 1;
    @(negedge Clk);
    start = 0;
    check("start_valid", valid, 0);
    check("start_addr", addr, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("line_valid", valid, 1);
      check("line_ipc", ipc, i);
      check("line_inst", inst, rom[i]);
      check("line_halted", halted, 0);
    end
    @(negedge Clk);
    check("line_halted_rise", halted, 1);
    check("line_valid_drop", valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("line_nofetch_valid", valid, 0);
      check("line_nofetch_addr", addr, 4);
    end
    #2 Reset_n = 1'b0;
    #1 check_reset("rst_halted");
    Reset_n = 1'b1;
    @(negedge Clk);
    start = 1; ready = 1;
    @(negedge Clk);
    start = 0;
    @(negedge Clk);
    check("s_ipc0", ipc, 0);
    @(negedge Clk);
    check("s_ipc1", ipc, 1);
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("stall_valid", valid, 1);
      check("stall_ipc", ipc, 1);
      check("stall_inst", inst, rom[1]);
      check("stall_addr", addr, 2);
    end
    ready = 1;
    @(negedge Clk);
    check("release_ipc", ipc, 2);
    check("release_inst", inst, rom[2]);
    @(negedge Clk);
    check("release_ipc3", ipc, 3);
    @(negedge Clk);
    check("halt_held_ipc", ipc, 4);
    check("halt_held_inst", inst, rom[4]);
    ready = 0; br = 1; tgt = 8'd1; start = 1;
    @(negedge Clk);
    br = 0; start = 0; ready = 1;
    check("br_valid", valid, 0);
    check("br_addr", addr, 1);
    check("br_halted", halted, 0);
    @(negedge Clk);
    check("br_tgt_valid", valid, 1);
    check("br_tgt_ipc", ipc, 1);
    check("br_tgt_inst", inst, rom[1]);
    check("br_tgt_halted", halted, 0);
    #2 Reset_n = 1'b0;
    #1 check_reset("rst_midrun");
    Reset_n = 1'b1;
    @(negedge Clk);
    start_w = 1; ready_w = 1;
    @(negedge Clk);
    start_w = 0;
    check("wrap_start_addr", addr_w, 254);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("wrap_valid", valid_w, 1);
      check("wrap_ipc", ipc_w, (254 + i) % 256);
    end
    random_run(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
